reg_file: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/reg_dump_seq.sv | 74 +++++++
 rtl/reg_file.sv | 63 ++++++
 tb/tb_reg_file.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file defaults and the dump sequencer state type.
package cpu_pkg;
    localparam int REG_COUNT_DEF = 16;
    localparam int DATA_W_DEF    = 64;
    localparam int ID_W_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;
endpackage

// File: rtl/reg_dump_seq.sv
// Dump sequencer: walks every register index once and streams registered beats.
module reg_dump_seq
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    output logic [ID_W-1:0]   rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    output logic [ID_W-1:0]   dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);
    dump_state_t     state, state_next;
    logic [ID_W-1:0] cnt, cnt_next;
    logic            beat;
    logic            done_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        beat       = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = DUMP;
                    cnt_next   = '0;
                end
            end
            DUMP: begin
                beat     = 1'b1;
                cnt_next = cnt + 1'b1;
                if (cnt == ID_W'(REG_COUNT - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            dump_valid <= beat;
            dump_done  <= done_next;
            if (beat) begin
                dump_idx  <= cnt;
                dump_data <= rd_data;
            end
        end
    end

    assign rd_idx    = cnt;
    assign dump_busy = (state == DUMP);
endmodule

// File: rtl/reg_file.sv
// Architectural register file with registered read port and a non-stalling dump side port.
module reg_file
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   reg_id,
    input  logic              reg_re,
    input  logic              reg_we,
    input  logic [DATA_W-1:0] reg_wd,
    output logic [DATA_W-1:0] reg_out,
    input  logic              dump_start,
    output logic              dump_valid,
    output logic [ID_W-1:0]   dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [ID_W-1:0]   seq_idx;
    logic [DATA_W-1:0] seq_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            reg_out <= '0;
        end else begin
            if (reg_we) begin
                regs[reg_id] <= reg_wd;
            end
            // Same-cycle write wins over the stored value on the read port.
            if (reg_re) begin
                reg_out <= reg_we ? reg_wd : regs[reg_id];
            end
        end
    end

    // The dump beat sees a write landing on its index at the same edge.
    assign seq_data = (reg_we && (reg_id == seq_idx)) ? reg_wd : regs[seq_idx];

    reg_dump_seq #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W)
    ) u_dump_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .rd_idx     (seq_idx),
        .rd_data    (seq_data),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table, randomized model comparison, dump sequences.
module tb_reg_file;
    logic        clk;
    logic        rst_n;
    logic [3:0]  reg_id;
    logic        reg_re;
    logic        reg_we;
    logic [63:0] reg_wd;
    logic [63:0] reg_out;
    logic        dump_start;
    logic        dump_valid;
    logic [3:0]  dump_idx;
    logic [63:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int checks;
    int failures;

    logic [63:0] mregs [16];
    logic [63:0] mout;

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  id;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_id     (reg_id),
        .reg_re     (reg_re),
        .reg_we     (reg_we),
        .reg_wd     (reg_wd),
        .reg_out    (reg_out),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mout = '0;
    endtask

    // One full dump with optional traffic: mode 1 writes during beats, mode 2 re-pulses start.
    task automatic dump_run(input int mode);
        int beats;
        int dones;
        int k;
        beats = 0;
        dones = 0;
        reg_re = 1'b0;
        reg_we = 1'b0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk($sformatf("dump%0d_busy_accept", mode), dump_busy, 1'b1);
        chk($sformatf("dump%0d_valid_accept", mode), dump_valid, 1'b0);
        for (int e = 1; e <= 19; e++) begin
            k = e - 1;
            reg_we = 1'b0;
            dump_start = 1'b0;
            if (mode == 1 && k == 9) begin
                reg_we = 1'b1; reg_id = 4'd9; reg_wd = 64'hAA;
            end
            if (mode == 1 && k == 4) begin
                reg_we = 1'b1; reg_id = 4'd2; reg_wd = 64'hBB;
            end
            if (mode == 2 && k == 4) dump_start = 1'b1;
            if (reg_we) mregs[reg_id] = reg_wd;
            step();
            chk($sformatf("dump%0d_valid_e%0d", mode, e), dump_valid, (e <= 16));
            if (e <= 16) begin
                chk($sformatf("dump%0d_idx_e%0d", mode, e), dump_idx, k[3:0]);
                chk($sformatf("dump%0d_data_e%0d", mode, e), dump_data, mregs[k]);
            end
            chk($sformatf("dump%0d_busy_e%0d", mode, e), dump_busy, (e <= 15));
            chk($sformatf("dump%0d_done_e%0d", mode, e), dump_done, (e == 17));
            if (dump_valid) beats++;
            if (dump_done) dones++;
        end
        reg_we = 1'b0;
        dump_start = 1'b0;
        chk($sformatf("dump%0d_beats", mode), beats, 16);
        chk($sformatf("dump%0d_dones", mode), dones, 1);
    endtask

    initial begin
        int dones;
        int stray_valid;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        reg_id = '0;
        reg_re = 1'b0;
        reg_we = 1'b0;
        reg_wd = '0;
        dump_start = 1'b0;
        model_clear();

        vecs[0] = '{1'b1, 1'b0, 4'd3, 64'hDEADBEEF_00000001, 64'h0};
        vecs[1] = '{1'b0, 1'b1, 4'd3, 64'h0, 64'hDEADBEEF_00000001};
        vecs[2] = '{1'b0, 1'b1, 4'd0, 64'h0, 64'h0};
        vecs[3] = '{1'b1, 1'b1, 4'd5, 64'h55, 64'h55};
        vecs[4] = '{1'b0, 1'b0, 4'd3, 64'h0, 64'h55};
        vecs[5] = '{1'b0, 1'b0, 4'd7, 64'h0, 64'h55};
        vecs[6] = '{1'b0, 1'b0, 4'd5, 64'h0, 64'h55};
        vecs[7] = '{1'b1, 1'b0, 4'd0, 64'h1234, 64'h55};
        vecs[8] = '{1'b0, 1'b1, 4'd0, 64'h0, 64'h1234};

        step();
        step();
        chk("rst_reg_out", reg_out, 64'h0);
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_dump_idx", dump_idx, 4'h0);
        chk("rst_dump_data", dump_data, 64'h0);
        chk("rst_dump_busy", dump_busy, 1'b0);
        chk("rst_dump_done", dump_done, 1'b0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 9; v++) begin
            reg_we = vecs[v].we;
            reg_re = vecs[v].re;
            reg_id = vecs[v].id;
            reg_wd = vecs[v].wd;
            if (reg_we) mregs[reg_id] = reg_wd;
            if (reg_re) mout = mregs[reg_id];
            step();
            chk($sformatf("vec%0d_reg_out", v), reg_out, vecs[v].exp);
        end

        for (int i = 0; i < 16; i++) begin
            reg_we = 1'b0;
            reg_re = 1'b1;
            reg_id = i[3:0];
            mout = mregs[i];
            step();
            chk($sformatf("readback_r%0d", i), reg_out, mout);
        end

        for (int n = 0; n < 300; n++) begin
            reg_we = 1'($urandom_range(0, 1));
            reg_re = 1'($urandom_range(0, 1));
            reg_id = 4'($urandom_range(0, 15));
            reg_wd = {$urandom, $urandom};
            if (reg_we) mregs[reg_id] = reg_wd;
            if (reg_re) mout = mregs[reg_id];
            step();
            chk($sformatf("rand%0d_reg_out", n), reg_out, mout);
        end

        reg_re = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reg_we = 1'b1;
            reg_id = i[3:0];
            reg_wd = 64'(i * 'h11);
            mregs[i] = reg_wd;
            step();
        end
        reg_we = 1'b0;
        step();

        dump_run(0);
        dump_run(1);
        dump_run(2);

        // Reset pulled mid-dump, between clock edges.
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        chk("abort_pre_valid", dump_valid, 1'b1);
        chk("abort_pre_idx", dump_idx, 4'd7);
        rst_n = 1'b0;
        #2;
        model_clear();
        chk("abort_reg_out", reg_out, 64'h0);
        chk("abort_dump_valid", dump_valid, 1'b0);
        chk("abort_dump_idx", dump_idx, 4'h0);
        chk("abort_dump_data", dump_data, 64'h0);
        chk("abort_dump_busy", dump_busy, 1'b0);
        chk("abort_dump_done", dump_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        stray_valid = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (dump_done) dones++;
            if (dump_valid) stray_valid++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_no_beats", stray_valid, 0);
        reg_re = 1'b1;
        reg_id = 4'd3;
        step();
        chk("abort_read_r3", reg_out, mregs[3]);
        reg_re = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
